// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive path: receiver FSM state
// encoding, default frame parameters and a width helper for the small
// counters (bit timer, bit index).
// No ports: this is a package imported by bit_timer and uart_rx_core.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Bits needed for a counter holding 0..count-1, never less than one.
  function automatic int counter_width(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer
// Bit-period counter for the UART receiver. After a clear it emits a
// one-cycle strobe HALF = CLKS_PER_BIT/2 cycles later (middle of the start
// bit), then one strobe every CLKS_PER_BIT cycles (middle of each later bit).
// Ports:
//   clk    - rising-edge system clock
//   n_rst  - asynchronous active-low reset
//   clear  - restart the half-bit phase on the next edge
//   enable - count while high, hold while low
//   strobe - one-cycle pulse at each bit-sampling point
module bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  localparam int CNT_W = counter_width(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  logic [CNT_W-1:0] count_q, count_d;
  logic             first_q, first_d;

  // first_q selects the shorter half-bit interval that lands on the middle
  // of the start bit; every interval after that is a full bit period.
  always_comb begin
    strobe  = enable && !clear &&
              (count_q == (first_q ? CNT_W'(HALF - 1) : CNT_W'(CLKS_PER_BIT - 1)));
    count_d = count_q;
    first_d = first_q;
    if (clear) begin
      count_d = '0;
      first_d = 1'b1;
    end else if (enable) begin
      if (strobe) begin
        count_d = '0;
        first_d = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      first_q <= 1'b1;
    end else begin
      count_q <= count_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Serial receive core: synchronises serial_in, detects the start edge,
// samples every bit at mid-period using bit_timer strobes, checks the stop
// bit and holds the last good byte in a one-entry buffer with status.
// Ports:
//   clk           - rising-edge system clock
//   n_rst         - asynchronous active-low reset
//   serial_in     - asynchronous serial line, idle high
//   data_read     - one-cycle acknowledge of rx_data from the consumer
//   rx_data       - last good byte, LSB is the first bit on the line
//   data_ready    - rx_data holds an unread byte
//   overrun_error - a byte was loaded over an unread one
//   framing_error - last frame's stop bit sampled low (sticky to next start)
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int IDX_W = counter_width(DATA_BITS);

  logic [1:0]           sync_q, sync_d;
  logic                 s_prev_q, s_prev_d;
  logic                 s;
  logic                 start_edge;
  rx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 framing_q, framing_d;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 strobe;

  assign s          = sync_q[1];
  assign start_edge = s_prev_q & ~s;

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (timer_clear),
    .enable(timer_enable),
    .strobe(strobe)
  );

  // Next-state logic for the synchroniser, the receive FSM and the output
  // buffer. The consumer acknowledge is applied first so that a LOAD in
  // the same cycle wins: the new byte stays ready and no overrun is flagged.
  always_comb begin
    sync_d       = {sync_q[0], serial_in};
    s_prev_d     = s;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    timer_clear  = 1'b0;
    timer_enable = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    if (data_read && data_ready_q) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          timer_clear = 1'b1;
          framing_d   = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (strobe) begin
          if (!s) begin
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (strobe) begin
          // Right shift with the new bit at the MSB leaves the first
          // received bit in the LSB once all data bits are in.
          shift_d   = {s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (strobe) begin
          if (s) begin
            state_d = LOAD;
          end else begin
            framing_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      LOAD: begin
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
        if (data_ready_q && !data_read) begin
          overrun_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset discards any partial frame and
  // parks the line history at idle-high so no false start edge appears.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q       <= 2'b11;
      s_prev_q     <= 1'b1;
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      s_prev_q     <= s_prev_d;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive core for the UART receiver path. It sits directly downstream of the bit-period counter and consumes that counter's per-bit strobes. It synchronises `serial_in`, detects the start bit, samples each bit at mid-period, checks the stop bit, and holds the received byte in a one-entry buffer with ready, overrun and framing status for the consumer.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; legal range 4..255.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `clk` input, 1 bit: rising-edge system clock.
- `n_rst` input, 1 bit: asynchronous, active-low reset.
- `serial_in` input, 1 bit: asynchronous serial line, idle high.
- `data_read` input, 1 bit: single-cycle pulse from the consumer acknowledging `rx_data`.
- `rx_data` output, `DATA_BITS` bits: last good received byte, LSB = first bit on the line.
- `data_ready` output, 1 bit: `rx_data` holds an unread byte.
- `overrun_error` output, 1 bit: a byte was loaded while `data_ready` was already high.
- `framing_error` output, 1 bit: the last frame's stop bit sampled low.

## Operation
- **Synchroniser:** two flops on `serial_in`, both reset to 1. The output is `s`. `s_prev` is one further flop, also reset to 1.
- **Start edge:** in IDLE, `s_prev==1 && s==0`. Call the cycle in which this is true E.
- **Constants:** HALF = `CLKS_PER_BIT/2`, integer division.
- **FSM states:**
  - IDLE: on a start edge, clear the bit timer and clear `framing_error`, then go to START.
  - START: at the strobe, `s==0` goes to DATA with bit index 0. `s==1` is a false start: go to IDLE with no flag change.
  - DATA: at each strobe, shift `s` in at the MSB and shift right. After strobe number `DATA_BITS`, go to STOP.
  - STOP: at the strobe, `s==1` goes to LOAD. `s==0` sets `framing_error` and goes to IDLE, leaving `rx_data` and `data_ready` unchanged.
  - LOAD: one cycle. `rx_data` takes the shift register, `data_ready` is set, then go to IDLE.
- **Overrun:** set in LOAD if `data_ready==1` and `data_read==0` that cycle. `rx_data` is still overwritten, so the newest byte wins.
- **`data_read`:**
  - Clears `data_ready` and `overrun_error` on the next edge.
  - If it coincides with LOAD, `data_ready` stays 1 and `overrun_error` is not set.
  - `data_read` while `data_ready==0` has no effect.
- **Errors:** `framing_error` is sticky until the next start edge. It does not block reception.
- **Reset:** asserting `n_rst` at any time returns the block to IDLE. Every output goes to 0 and the shift register goes to 0. A partial frame is discarded.

## Timing
- All timing below is measured from edge cycle E, on `s`. `s` lags `serial_in` by 2 cycles.
- **Start-bit sample:** at E+HALF.
- **Data bit k (k = 0..`DATA_BITS`-1):** at E+HALF+(k+1)·`CLKS_PER_BIT`.
- **Stop bit:** at E+HALF+(`DATA_BITS`+1)·`CLKS_PER_BIT`. Call this cycle T.
- **Good frame:** LOAD occurs at T+1, and `rx_data`/`data_ready` are visible from T+2.
- **Bad stop bit:** `framing_error` is visible from T+1.
- **Back-to-back frames:** the FSM is in IDLE from T+1 (bad stop) or T+2 (good stop). A start edge is accepted in that cycle, so frames with a single stop bit back-to-back are supported.
- **Throughput:** one frame per (`DATA_BITS`+2)·`CLKS_PER_BIT` cycles. The output buffer is one entry deep.

## Structure
- **Shared package `uart_rx_pkg`:**
  - enum `rx_state_t`: IDLE, START, DATA, STOP, LOAD.
  - Function `clog2`-based width for the bit timer.
  - Default parameter constants.
- **Sub-module `bit_timer`:**
  - Counts clock cycles.
  - Takes `clear` and `enable` inputs.
  - Produces a one-cycle `strobe` at HALF cycles after `clear`, then every `CLKS_PER_BIT` cycles.
  - Enabled in START, DATA and STOP.
  - The bit index counter stays inside `uart_rx_core`.

## Test plan
All scenarios use `CLKS_PER_BIT`=10 and `DATA_BITS`=8.
- **Reset:** reset, then idle line for 20 cycles -> all outputs 0, no state change.
- **Good byte:** frame 0xA5 with stop=1 -> `rx_data`=0xA5 and `data_ready`=1 at E+97. `data_read` pulse -> `data_ready`=0 next cycle.
- **False start:** `serial_in` low for 3 cycles, then high -> no flags; a following valid 0x3C frame is received correctly.
- **Framing error:** frame 0x55 with stop=0 -> `framing_error`=1 at E+96, `data_ready` stays 0, `rx_data` unchanged. The next valid start edge clears it.
- **Overrun:** 0x11 then 0x22 back-to-back with no `data_read` -> `rx_data`=0x22, `overrun_error`=1. A second case with `data_read` coincident with the LOAD cycle of 0x22 -> `overrun_error` stays 0 and `data_ready` stays 1.
- **Mid-frame reset:** assert `n_rst` at E+40 of frame 0xFF -> outputs 0 immediately. After release, frame 0x81 is received correctly.
